// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: data width, opcodes,
// fetch FSM encodings and the branch displacement helper.
package ifetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    ST_RST   = 2'b00,
    ST_FETCH = 2'b01,
    ST_HOLD  = 2'b10
  } fetch_state_e;

  // Sign-extended 16-bit immediate scaled to a byte offset.
  function automatic logic [XLEN-1:0] branch_offset(input logic [15:0] imm);
    branch_offset = {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_unit_next_pc_logic.sv
// Combinational next-PC selection for the fetch stage: jump over taken branch
// over sequential; all arithmetic wraps modulo 2^32.
module next_pc_logic
  import ifetch_unit_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] next_pc
);

  // Select jump target, branch target or fall-through.
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4 + branch_offset(instr[15:0]);
    end else begin
      next_pc = pc_plus4;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word fetch per instruction
// and holds the fetched word until decode accepts it.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic        instr_valid,
  input  logic        id_ready,
  output logic [31:0] pc_plus4,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero
);

  localparam logic [31:0] PC_START    = {PC_RESET[31:2], 2'b00};
  localparam logic [31:0] PC_START_P4 = PC_START + 32'd4;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_plus4_q, pc_plus4_d;
  logic [31:0]  instr_q, instr_d;
  logic         instr_valid_q, instr_valid_d;
  logic         imem_req_q, imem_req_d;
  logic [31:0]  next_pc_s;

  next_pc_logic u_next_pc (
    .pc_plus4 (pc_plus4_q),
    .instr    (instr_q),
    .jump     (jump),
    .branch   (branch),
    .zero     (zero),
    .next_pc  (next_pc_s)
  );

  // Next-state and register update decisions for the fetch FSM.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pc_plus4_d    = pc_plus4_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    case (state_q)
      ST_RST: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_rvalid) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = ST_HOLD;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (id_ready) begin
          pc_d          = next_pc_s;
          pc_plus4_d    = next_pc_s + 32'd4;
          instr_valid_d = 1'b0;
          state_d       = ST_FETCH;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d       = ST_RST;
        instr_valid_d = 1'b0;
      end
    endcase
    // Request is a flop so it rises on the same edge the FSM enters FETCH.
    imem_req_d = (state_d == ST_FETCH);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_RST;
      pc_q          <= PC_START;
      pc_plus4_q    <= PC_START_P4;
      instr_q       <= 32'h0000_0000;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_plus4_q    <= pc_plus4_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      imem_req_q    <= imem_req_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign op          = instr_q[31:26];
  assign instr_valid = instr_valid_q;
  assign pc_plus4    = pc_plus4_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed self-checking bench for ifetch_unit: reset, sequential, branch,
// jump, stall and wrap-around scenarios with hand-computed expectations.
module tb_ifetch_unit;

  logic        clk;
  logic        reset_n;

  logic        a_req, a_valid, a_rvalid, a_ready, a_jump, a_branch, a_zero;
  logic [31:0] a_addr, a_rdata, a_instr, a_pc4;
  logic [5:0]  a_op;

  logic        b_req, b_valid, b_rvalid, b_ready;
  logic [31:0] b_addr, b_rdata, b_instr, b_pc4;
  logic [5:0]  b_op;

  int checks   = 0;
  int failures = 0;

  ifetch_unit #(.PC_RESET(32'h0000_0000)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .imem_req(a_req), .imem_addr(a_addr), .imem_rvalid(a_rvalid), .imem_rdata(a_rdata),
    .instr(a_instr), .op(a_op), .instr_valid(a_valid), .id_ready(a_ready),
    .pc_plus4(a_pc4), .jump(a_jump), .branch(a_branch), .zero(a_zero)
  );

  ifetch_unit #(.PC_RESET(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .imem_req(b_req), .imem_addr(b_addr), .imem_rvalid(b_rvalid), .imem_rdata(b_rdata),
    .instr(b_instr), .op(b_op), .instr_valid(b_valid), .id_ready(b_ready),
    .pc_plus4(b_pc4), .jump(1'b0), .branch(1'b0), .zero(1'b0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n  = 1'b0;
    a_rvalid = 1'b0; a_rdata = 32'h0; a_ready = 1'b0;
    a_jump   = 1'b0; a_branch = 1'b0; a_zero = 1'b0;
    b_rvalid = 1'b0; b_rdata = 32'h0; b_ready = 1'b0;

    // Reset held
    tick(); tick();
    chk("rst_req",   {31'd0, a_req},   32'd0);
    chk("rst_valid", {31'd0, a_valid}, 32'd0);
    chk("rst_addr",  a_addr,           32'h0);
    chk("rst_instr", a_instr,          32'h0);
    chk("rst_pc4",   a_pc4,            32'h4);
    chk("rst_b_addr", b_addr,          32'hFFFF_FFFC);
    chk("rst_b_pc4",  b_pc4,           32'h0);
    reset_n = 1'b1;
    chk("rst_rel_req", {31'd0, a_req}, 32'd0);
    tick();
    chk("fetch0_req",  {31'd0, a_req}, 32'd1);
    chk("fetch0_addr", a_addr,         32'h0);

    // Sequential zero-wait fetch
    a_rvalid = 1'b1; a_rdata = 32'h2008_0005; a_ready = 1'b1;
    tick();
    chk("seq_valid", {31'd0, a_valid}, 32'd1);
    chk("seq_op",    {26'd0, a_op},    32'h08);
    chk("seq_instr", a_instr,          32'h2008_0005);
    chk("seq_pc4",   a_pc4,            32'h4);
    chk("seq_req",   {31'd0, a_req},   32'd0);
    a_rdata = 32'h2009_0001;
    tick();
    chk("seq_addr",  a_addr,           32'h4);
    chk("seq_req2",  {31'd0, a_req},   32'd1);
    chk("seq_vld0",  {31'd0, a_valid}, 32'd0);
    tick();
    a_rdata = 32'h1109_FFFE;
    tick();
    chk("br_fetch_addr", a_addr, 32'h8);

    // Branch taken: 0xC + (-8) = 0x4
    tick();
    chk("br_op",  {26'd0, a_op}, 32'h04);
    chk("br_pc4", a_pc4,         32'hC);
    a_branch = 1'b1; a_zero = 1'b1; a_rdata = 32'h2009_0001;
    tick();
    chk("br_taken_addr", a_addr, 32'h4);
    chk("br_taken_pc4",  a_pc4,  32'h8);
    a_branch = 1'b0; a_zero = 1'b0;
    tick();
    a_rdata = 32'h1109_FFFE;
    tick();
    chk("br2_fetch_addr", a_addr, 32'h8);
    tick();
    // Branch not taken
    a_branch = 1'b1; a_zero = 1'b0; a_rdata = 32'h0000_0000;
    tick();
    chk("br_nt_addr", a_addr, 32'hC);
    a_branch = 1'b0;
    tick();
    a_rdata = 32'h0800_0040;
    tick();
    chk("j_fetch_addr", a_addr, 32'h10);
    tick();
    chk("j_op", {26'd0, a_op}, 32'h02);

    // Jump beats branch
    a_jump = 1'b1; a_branch = 1'b1; a_zero = 1'b1;
    tick();
    chk("j_addr", a_addr, 32'h100);
    chk("j_pc4",  a_pc4,  32'h104);
    a_jump = 1'b0; a_branch = 1'b0; a_zero = 1'b0; a_rvalid = 1'b0;

    // Memory wait states
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_req",   {31'd0, a_req},   32'd1);
      chk("wait_addr",  a_addr,           32'h100);
      chk("wait_valid", {31'd0, a_valid}, 32'd0);
    end
    a_rvalid = 1'b1; a_rdata = 32'h2008_0007; a_ready = 1'b0;
    tick();
    chk("stall_valid", {31'd0, a_valid}, 32'd1);
    chk("stall_instr", a_instr,          32'h2008_0007);

    // Decode stall with stray response in HOLD
    a_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_instr", a_instr,          32'h2008_0007);
      chk("hold_valid", {31'd0, a_valid}, 32'd1);
      chk("hold_pc4",   a_pc4,            32'h104);
      chk("hold_req",   {31'd0, a_req},   32'd0);
    end
    a_rvalid = 1'b0; a_ready = 1'b1;
    tick();
    chk("post_stall_addr", a_addr, 32'h104);
    chk("post_stall_req",  {31'd0, a_req}, 32'd1);
    a_rvalid = 1'b1; a_rdata = 32'h2008_0005; a_ready = 1'b0;
    tick();
    chk("pre_arst_valid", {31'd0, a_valid}, 32'd1);

    // Asynchronous reset between clock edges
    #2 reset_n = 1'b0;
    #1;
    chk("arst_req",   {31'd0, a_req},   32'd0);
    chk("arst_valid", {31'd0, a_valid}, 32'd0);
    chk("arst_addr",  a_addr,           32'h0);
    chk("arst_instr", a_instr,          32'h0);
    a_rvalid = 1'b0;

    // PC wrap on instance with PC_RESET=0xFFFFFFFC
    tick();
    reset_n = 1'b1;
    tick();
    chk("wrap_req",  {31'd0, b_req}, 32'd1);
    chk("wrap_addr", b_addr,         32'hFFFF_FFFC);
    b_rvalid = 1'b1; b_rdata = 32'h2008_0005; b_ready = 1'b1;
    tick();
    chk("wrap_valid", {31'd0, b_valid}, 32'd1);
    chk("wrap_pc4",   b_pc4,            32'h0);
    b_rvalid = 1'b0;
    tick();
    chk("wrap_next_addr", b_addr, 32'h0);
    chk("wrap_next_pc4",  b_pc4,  32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
